// File: rtl/ram_ctrl4096x16.sv
// Command FIFO plus sequencer for a single-port 4096x16 RAM with a shared bidirectional data bus.
// Writes stream one per cycle; reads take an address and a capture cycle; read->write inserts a turnaround.
module ram_ctrl4096x16 #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    inout  wire  [DW-1:0] mem_data
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = 1 + AW + DW;

    typedef enum logic [2:0] {StIdle, StWr, StRdA, StRdC, StTurn} state_e;

    state_e        state_q, state_d;
    logic [EW-1:0] fifo_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;
    logic          last_push_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [EW-1:0] head;
    logic          push, pop, head_ok, head_we, drive;

    assign req_ready = rst_n && (count_q != (PW+1)'(DEPTH));
    assign push      = req_valid && req_ready;
    assign head      = fifo_q[rptr_q];
    assign head_we   = head[EW-1];
    // An entry must sit in the FIFO for one full cycle before it can be popped.
    assign head_ok   = (count_q != '0) && !((count_q == (PW+1)'(1)) && last_push_q);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wptr_q] <= {req_we, req_addr, req_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            last_push_q <= 1'b0;
        end else begin
            last_push_q <= push;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle, StWr, StTurn: begin
                if (head_ok) begin
                    pop     = 1'b1;
                    state_d = head_we ? StWr : StRdA;
                end else begin
                    state_d = StIdle;
                end
            end
            StRdA: state_d = StRdC;
            StRdC: begin
                if (!head_ok) begin
                    state_d = StIdle;
                end else if (head_we) begin
                    state_d = StTurn;
                end else begin
                    pop     = 1'b1;
                    state_d = StRdA;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_rw = (state_q != StWr);
        drive  = (state_q == StWr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (pop) begin
            addr_q  <= head[DW +: AW];
            wdata_q <= head[DW-1:0];
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = drive ? wdata_q : {DW{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= (state_q == StRdC);
            if (state_q == StRdC) begin
                resp_rdata <= mem_data;
            end
        end
    end

endmodule

// File: doc/ram_ctrl4096x16.md
RAM_CTRL4096X16 -- requirements
Module: ram_ctrl4096x16

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning request FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 12, meaning address width.
REQ-003 SHALL have parameter DW, default 16, meaning data width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  requester presents a command.
REQ-007 req_ready  output  1  FIFO can accept; transfer when req_valid && req_ready.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AW  word address.
REQ-010 req_wdata  input  DW  write data.
REQ-011 resp_valid  output  1  one-cycle pulse, read data valid; no backpressure.
REQ-012 resp_rdata  output  DW  read data, held until the next resp_valid.
REQ-013 mem_addr  output  AW  to RAM addr.
REQ-014 mem_rw  output  1  to RAM rw; 1 = read, 0 = write.
REQ-015 mem_data  inout  DW  shared RAM data bus; driven only in WR, high-Z otherwise.

Function
REQ-016 SHALL buffer accepted commands {we, addr, wdata} in a DEPTH-entry FIFO with wrapping read/write pointers and an occupancy counter 0..DEPTH.
REQ-017 req_ready SHALL equal (count != DEPTH), registered-state based; a push attempted when full is ignored and FIFO contents are unchanged.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; push into an empty FIFO is not poppable until the following cycle.
REQ-019 FSM states SHALL be IDLE, WR, RD_A, RD_C, TURN.
REQ-020 IDLE: FIFO non-empty -> pop; head write -> WR, head read -> RD_A; else stay IDLE.
REQ-021 WR (1 cycle): mem_rw=0, mem_addr/mem_data from popped entry; RAM writes at the closing edge. Next: pop into WR or RD_A if non-empty, else IDLE.
REQ-022 RD_A (1 cycle): mem_rw=1, mem_addr driven, bus released; always -> RD_C.
REQ-023 RD_C (1 cycle): mem_rw=1, mem_addr held; mem_data captured into resp_rdata at the closing edge; resp_valid=1 in the next cycle. Next: head read -> RD_A (pop); head write -> TURN (no pop); empty -> IDLE.
REQ-024 TURN (1 cycle): bus high-Z, mem_rw=1; pop head write -> WR.
REQ-025 Latency: command accepted at edge E; its WR/RD_A cycle begins at earliest E+2 edges; read resp_valid 2 cycles after RD_A starts.
REQ-026 Throughput: back-to-back writes 1/cycle; reads 1 per 2 cycles; read->write costs one TURN cycle; write->read costs none.
REQ-027 Commands SHALL execute strictly in acceptance order; responses return in read order.
REQ-028 mem_data SHALL never be driven in any state other than WR (no bus contention with RAM read drive).
REQ-029 Address bits [AW-1:AW-2] are bank select and SHALL be passed through unmodified; no address arithmetic.

Reset
REQ-030 When rst_n=0 at a rising edge: FIFO empty, pointers 0, state IDLE, mem_rw=1, mem_addr=0, mem_data high-Z, resp_valid=0, resp_rdata=0.
REQ-031 req_ready SHALL be 0 while rst_n=0 and 1 from the first cycle after release.
REQ-032 Reset asserted mid-operation SHALL abort any in-flight command, discard FIFO contents, and emit no resp_valid for aborted reads.

Verification
REQ-033 Write addr 0x000 data 0xA5A5, then read 0x000 -> exactly one resp_valid, resp_rdata=0xA5A5, 4 cycles of WR/TURN-free path measured per REQ-025.
REQ-034 Writes to 0x3FF, 0x400, 0x800, 0xC00 with data 0x1111..0x4444, read back in same order -> 0x1111, 0x2222, 0x3333, 0x4444 (bank boundaries).
REQ-035 4 writes held valid continuously -> req_ready drops when count=4, 5th command accepted only after a pop; WR cycles consecutive, no gaps.
REQ-036 Read 0x010 followed immediately by write 0x010=0xBEEF -> TURN cycle observed, mem_data high-Z in RD_A/RD_C/TURN, read returns old value.
REQ-037 rst_n low during RD_C with 2 queued entries -> no resp_valid, req_ready=0 during reset, FIFO empty and state IDLE after release.
REQ-038 Push while full with different data -> ignored; subsequent readback shows only accepted data.
